burst_timer_ctrl: RTL
=====================

# burst_timer_ctrl

Controller that drives a flex_counter and consumes its rollover flag. On a start request it latches a period and a burst length, clears and enables the counter, and emits one `tick` per counter rollover. After `burst_len` ticks it stops the counter and pulses `done`. It sits directly upstream of flex_counter, driving its `clear`, `count_enable` and `rollover_val`, and downstream of its `rollover_flag`.

## Interface
- `NUM_BITS`, 4: counter width; width of `period` / `cnt_rollover_val`
- `BURST_BITS`, 4: width of `burst_len` / `burst_count`

Ports:
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  reset, synchronous, active-high
- `start`  in  1  begin burst; sampled only in IDLE
- `period`  in  NUM_BITS  counter rollover value; latched on accepted start
- `burst_len`  in  BURST_BITS  ticks per burst; latched on accepted start
- `cnt_rollover_flag`  in  1  from flex_counter `rollover_flag`
- `cnt_clear`  out  1  to flex_counter `clear`
- `cnt_count_enable`  out  1  to flex_counter `count_enable`
- `cnt_rollover_val`  out  NUM_BITS  to flex_counter `rollover_val`; the latched period
- `busy`  out  1  high in every state except IDLE
- `tick`  out  1  one-cycle pulse per detected rollover
- `burst_count`  out  BURST_BITS  ticks issued in the current burst
- `done`  out  1  one-cycle pulse at burst completion
- `cfg_err`  out  1  one-cycle pulse with `done` when the latched config was rejected

## Operation
- States: IDLE, ARM, RUN, FINISH.
- IDLE:
  - On `start`=1, latch `period` and `burst_len`, zero `burst_count`, go to ARM.
  - `start` has no effect in any other state.
- ARM (exactly 1 cycle):
  - `cnt_clear`=1, `cnt_count_enable`=0.
  - If latched period<2 or burst_len==0, go to FINISH with the error marked; otherwise go to RUN.
  - Period 0/1 is rejected because the counter flag would never produce clean edges.
- RUN:
  - `cnt_count_enable`=1, `cnt_clear`=0.
  - A rising edge of `cnt_rollover_flag` (current=1, registered previous=0) counts as one rollover.
  - Each rollover increments `burst_count` and pulses `tick`.
  - When the increment makes `burst_count`==`burst_len`, go to FINISH.
- FINISH (exactly 1 cycle):
  - `cnt_count_enable`=0, `cnt_clear`=1, `done`=1.
  - `cfg_err`=1 only if the error is marked.
  - Go to IDLE.
  - `burst_count` holds its final value until the next accepted start.
- `cnt_rollover_val` always equals the latched period. It is 0 after reset.
- A `cnt_rollover_flag` held high, for example while counting is disabled, produces no further ticks. The edge-detect register is cleared on entry to RUN.
- Width rules:
  - `burst_count` cannot wrap, because it stops at `burst_len` ≤ 2^BURST_BITS−1.
  - The ARM validity check uses an unsigned compare.

## Timing
- Reset: all outputs 0, state IDLE, latched config 0, edge register 0.
- `rst` mid-burst returns to IDLE on the next edge.
  - No `done` is issued.
  - `cnt_count_enable` drops the same edge.
- Latency:
  - Start sampled at edge E0: ARM during cycle E0→E1, RUN from E1.
  - First `tick` is high during the cycle beginning at edge E1+period+1.
  - Later ticks follow every `period` cycles.
- `done` is high the cycle after the final `tick`. `busy` falls one cycle after `done`.
- `tick` and `done` are never high in the same cycle.
- `start` held high continuously: a new burst is accepted in the first IDLE cycle after `done`.

## Configuration
- `BURST_TIMER_ABORT_EN`: when defined, adds input `abort` (1 bit) and output `aborted` (1 bit, reset 0).
  - `abort`=1 in ARM or RUN goes to FINISH, with `done`=0 and `aborted`=1 in that cycle.
  - `abort` wins over a simultaneous final rollover; that rollover's `tick` is suppressed and `burst_count` is not incremented.
  - `abort` in IDLE or FINISH is ignored.
- When undefined, neither port exists and the behaviour is exactly as above.

## Structure
- `burst_timer_pkg`: state enum typedef `burst_state_t` (IDLE, ARM, RUN, FINISH), constant `MIN_PERIOD` = 2.
- Sub-module `rise_detect`: 1-bit registered rising-edge detector with a synchronous clear input. Used on `cnt_rollover_flag`.

## Test plan
- Reset: assert `rst` for 2 cycles with `start`=1 → all outputs 0, `busy`=0; no burst begins until `rst` falls.
- Nominal: period=3, burst_len=4, start pulse → 4 ticks spaced 3 cycles apart, first at E1+4, `burst_count`=4, one `done`, `cfg_err`=0, `cnt_clear` high in ARM and FINISH only.
- Config reject: period=1, burst_len=5 → ARM, FINISH, `done`=1 and `cfg_err`=1 together, zero ticks, `cnt_count_enable` never high; repeat with period=6, burst_len=0 → same result.
- Stuck flag: hold `cnt_rollover_flag`=1 for 10 cycles in RUN → exactly one tick.
- Start while busy: extra `start` pulses during RUN are ignored; `start` held high → second burst's ARM is the cycle after `busy` falls.
- Reset mid-burst (period=5, burst_len=3, after 1 tick) → next cycle: IDLE, `cnt_count_enable`=0, no `done`; under `BURST_TIMER_ABORT_EN`, repeat using `abort` instead → `aborted`=1, `done`=0, `cnt_clear`=1.

Source files
------------

// File: rtl/burst_timer_pkg.sv
// Shared types and constants for the burst timer controller.
package burst_timer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARM    = 2'd1,
        RUN    = 2'd2,
        FINISH = 2'd3
    } burst_state_t;

    // Smallest period that still gives the counter flag a low phase between rollovers.
    localparam int unsigned MIN_PERIOD = 2;

endpackage

// File: rtl/rise_detect.sv
// Registered rising-edge detector; the sync clear forgets the previous sample.
module rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic d,
    output logic rise
);

    logic prev;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            prev <= 1'b0;
        end else begin
            prev <= d;
        end
    end

    assign rise = d & ~prev;

endmodule

// File: rtl/burst_timer_ctrl.sv
// Burst controller in front of a flex_counter: one tick per counter rollover, done after burst_len ticks.
// Optional BURST_TIMER_ABORT_EN adds an abort input and an aborted status pulse.
module burst_timer_ctrl
    import burst_timer_pkg::*;
#(
    parameter int NUM_BITS   = 4,
    parameter int BURST_BITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [NUM_BITS-1:0]   period,
    input  logic [BURST_BITS-1:0] burst_len,
    input  logic                  cnt_rollover_flag,
`ifdef BURST_TIMER_ABORT_EN
    input  logic                  abort,
    output logic                  aborted,
`endif
    output logic                  cnt_clear,
    output logic                  cnt_count_enable,
    output logic [NUM_BITS-1:0]   cnt_rollover_val,
    output logic                  busy,
    output logic                  tick,
    output logic [BURST_BITS-1:0] burst_count,
    output logic                  done,
    output logic                  cfg_err
);

    burst_state_t          state;
    burst_state_t          next_state;
    logic [NUM_BITS-1:0]   period_q;
    logic [BURST_BITS-1:0] len_q;
    logic                  err_q;
    logic                  abort_q;
    logic                  abort_req;
    logic                  rise;
    logic                  cfg_bad;
    logic                  load;
    logic                  count_inc;
    logic                  set_err;
    logic                  set_abort;

`ifdef BURST_TIMER_ABORT_EN
    assign abort_req = abort;
    assign aborted   = (state == FINISH) && abort_q;
`else
    assign abort_req = 1'b0;
`endif

    // Prev sample is dropped while arming so a flag left high cannot be mistaken for stale history.
    rise_detect u_rise (
        .clk   (clk),
        .rst   (rst),
        .clear (state == ARM),
        .d     (cnt_rollover_flag),
        .rise  (rise)
    );

    assign cfg_bad = (32'(period_q) < MIN_PERIOD) || (len_q == '0);

    always_comb begin
        next_state = state;
        load       = 1'b0;
        count_inc  = 1'b0;
        set_err    = 1'b0;
        set_abort  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = ARM;
                    load       = 1'b1;
                end
            end
            ARM: begin
                if (abort_req) begin
                    next_state = FINISH;
                    set_abort  = 1'b1;
                end else if (cfg_bad) begin
                    next_state = FINISH;
                    set_err    = 1'b1;
                end else begin
                    next_state = RUN;
                end
            end
            RUN: begin
                // Abort takes priority, so a rollover seen on the same edge is discarded.
                if (abort_req) begin
                    next_state = FINISH;
                    set_abort  = 1'b1;
                end else if (burst_count == len_q) begin
                    next_state = FINISH;
                end else if (rise) begin
                    count_inc = 1'b1;
                end
            end
            FINISH: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            period_q    <= '0;
            len_q       <= '0;
            burst_count <= '0;
            tick        <= 1'b0;
            err_q       <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            state <= next_state;
            tick  <= count_inc;
            if (load) begin
                period_q    <= period;
                len_q       <= burst_len;
                burst_count <= '0;
                err_q       <= 1'b0;
                abort_q     <= 1'b0;
            end else begin
                if (count_inc) begin
                    burst_count <= burst_count + BURST_BITS'(1);
                end
                if (set_err) begin
                    err_q <= 1'b1;
                end
                if (set_abort) begin
                    abort_q <= 1'b1;
                end
            end
        end
    end

    assign cnt_clear        = (state == ARM) || (state == FINISH);
    assign cnt_count_enable = (state == RUN);
    assign cnt_rollover_val = period_q;
    assign busy             = (state != IDLE);
    assign done             = (state == FINISH) && !abort_q;
    assign cfg_err          = (state == FINISH) && err_q && !abort_q;

endmodule
